// File: rtl/llp_pkg.sv
// Shared types and parameter defaults for the laned logic pipe.
// Pure declarations; no logic and no latency.
// No flow control; imported by llp_lane and laned_logic_pipe.
package llp_pkg;

  // Default geometry: two 8-bit lanes, 16-bit datapath.
  localparam int LLP_LANE_W_DEF = 8;
  localparam int LLP_LANES_DEF  = 2;

  // Per-lane operation encoding as carried on in_op.
  typedef enum logic [1:0] {
    LLP_AND  = 2'b00,
    LLP_OR   = 2'b01,
    LLP_XOR  = 2'b10,
    LLP_NAND = 2'b11
  } llp_op_e;

  // Interpret a raw 2-bit op field; every encoding is a legal op.
  function automatic llp_op_e llp_op_decode(input logic [1:0] raw);
    return llp_op_e'(raw);
  endfunction

endpackage

// File: rtl/llp_lane.sv
// One lane of bitwise logic: op(a, b) when enabled, a passed through otherwise.
// Purely combinational, zero latency.
// No flow control; the enclosing pipe stage owns all handshaking.
module llp_lane
  import llp_pkg::*;
#(
  parameter int LANE_W = LLP_LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [1:0]        op,
  input  logic              en,
  output logic [LANE_W-1:0] res
);

  logic [LANE_W-1:0] op_res;

  // Evaluate the selected bitwise operation on the two operands.
  always_comb begin
    op_res = a & b;
    case (llp_op_decode(op))
      LLP_AND:  op_res = a & b;
      LLP_OR:   op_res = a | b;
      LLP_XOR:  op_res = a ^ b;
      LLP_NAND: op_res = ~(a & b);
    endcase
  end

  // A disabled lane leaves operand A untouched.
  always_comb begin
    res = en ? op_res : a;
  end

endmodule

// File: rtl/laned_logic_pipe.sv
// Two-stage valid/ready pipe applying a per-lane bitwise op (AND/OR/XOR/NAND) to A and B.
// Latency 2 cycles from input transfer to out_valid; one transfer per cycle when unstalled.
// Backpressure: a stage advances when its successor is empty or moving; in_ready = S1 can advance.
// Optional feature macro LLP_ZERO_FLAG_EN adds the registered per-lane zero flag port out_zero.
module laned_logic_pipe
  import llp_pkg::*;
#(
  parameter int  LANE_W = LLP_LANE_W_DEF,
  parameter int  LANES  = LLP_LANES_DEF,
  localparam int W      = LANE_W * LANES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_op,
  input  logic [LANES-1:0] in_lane_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res
`ifdef LLP_ZERO_FLAG_EN
  ,
  output logic [LANES-1:0] out_zero
`endif
);

  // Stage 1: captured operands.
  logic             s1_vld_q, s1_vld_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [LANES-1:0] s1_en_q, s1_en_d;

  // Stage 2: computed result.
  logic             s2_vld_q, s2_vld_d;
  logic [W-1:0]     s2_res_q, s2_res_d;

  // Handshake controls.
  logic             s1_adv;
  logic             s2_adv;
  logic             s1_load;
  logic             s2_load;

  // Combinational lane results computed from stage-1 operands.
  logic [W-1:0]     lane_res;

  // Advance chain: S2 frees when empty or drained, S1 frees when empty or S2 frees.
  always_comb begin
    s2_adv  = !s2_vld_q || out_ready;
    s1_adv  = !s1_vld_q || s2_adv;
    s1_load = in_valid && s1_adv;
    s2_load = s1_vld_q && s2_adv;
  end

  assign in_ready = s1_adv;

  // Valid bits move forward only when the receiving stage advances.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (s1_adv) begin
      s1_vld_d = in_valid;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
    end
  end

  // Stage-1 operand capture; held when nothing new is accepted.
  always_comb begin
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_op_d = s1_op_q;
    s1_en_d = s1_en_q;
    if (s1_load) begin
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_op_d = in_op;
      s1_en_d = in_lane_en;
    end
  end

  // Stage-2 result capture; held while stalled so the output stays stable.
  always_comb begin
    s2_res_d = s2_res_q;
    if (s2_load) begin
      s2_res_d = lane_res;
    end
  end

  // One combinational lane slice per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    llp_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .a  (s1_a_q[g*LANE_W +: LANE_W]),
      .b  (s1_b_q[g*LANE_W +: LANE_W]),
      .op (s1_op_q),
      .en (s1_en_q[g]),
      .res(lane_res[g*LANE_W +: LANE_W])
    );
  end

  // Valid bits clear asynchronously so in-flight entries vanish at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  // Stage-1 datapath is never observed while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_op_q <= s1_op_d;
    s1_en_q <= s1_en_d;
  end

  // Stage-2 result drives out_res directly and must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_res_q <= '0;
    end else begin
      s2_res_q <= s2_res_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_res   = s2_res_q;

`ifdef LLP_ZERO_FLAG_EN
  logic [LANES-1:0] lane_zero;
  logic [LANES-1:0] s2_zero_q, s2_zero_d;

  // Per-lane zero detect on the result about to enter stage 2.
  always_comb begin
    lane_zero = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_zero[i] = (lane_res[i*LANE_W +: LANE_W] == '0);
    end
  end

  // Zero flags load together with the result so they always describe it.
  always_comb begin
    s2_zero_d = s2_zero_q;
    if (s2_load) begin
      s2_zero_d = lane_zero;
    end
  end

  // Zero flags register, cleared at reset like the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_zero_q <= '0;
    end else begin
      s2_zero_q <= s2_zero_d;
    end
  end

  assign out_zero = s2_zero_q;
`endif

endmodule
